seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a two-digit 7-segment display.
// A two-digit segment pattern is accepted over a valid/ready handshake into a
// one-slot pending register. The pending pattern moves into the shadow
// register only when a frame starts, so a frame always shows one consistent
// pattern. Each frame is DIG0 (units), an optional blank gap, DIG1 (tens) and
// another optional blank gap.
//
// Ports:
//   clk        in   clock
//   rstn       in   synchronous reset, active-low
//   en         in   1 = scan, 0 = blank display and park the FSM in IDLE
//   s_valid    in   input pattern valid
//   s_ready    out  pending slot empty (registered)
//   s_data     in   {tens[13:7], units[6:0]}, active-high, bit6=a .. bit0=g
//   seg_out    out  shared segment bus, active-high (registered)
//   dig_en_n   out  digit enables, active-low, [0]=units, [1]=tens (registered)
//   frame_done out  one-cycle pulse in the first cycle of each new frame
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [13:0] s_data,
    output logic [6:0]  seg_out,
    output logic [1:0]  dig_en_n,
    output logic        frame_done
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DIG0 = 3'd1;
    localparam logic [2:0] ST_GAP0 = 3'd2;
    localparam logic [2:0] ST_DIG1 = 3'd3;
    localparam logic [2:0] ST_GAP1 = 3'd4;

    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    // The timer holds "cycles remaining minus one" in the current state, so a
    // state is left on the edge where the timer reads zero.
    localparam logic [TW-1:0] ZERO_T   = TW'(0);
    localparam logic [TW-1:0] ONE_T    = TW'(1);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic          boundary_s;
    logic          enter_dig0_s;

    logic          pend_full_r;
    logic          pend_full_nxt_s;
    logic [13:0]   pend_r;
    logic [13:0]   pend_nxt_s;
    logic [13:0]   shadow_r;
    logic [13:0]   shadow_nxt_s;
    logic          xfer_s;
    logic          commit_s;

    logic          s_ready_r;
    logic [6:0]    seg_out_r;
    logic [6:0]    seg_nxt_s;
    logic [1:0]    dig_en_n_r;
    logic [1:0]    dig_nxt_s;
    logic          frame_done_r;

    assign s_ready    = s_ready_r;
    assign seg_out    = seg_out_r;
    assign dig_en_n   = dig_en_n_r;
    assign frame_done = frame_done_r;

    // Tens digit after optional leading-zero suppression (7'h7E is "0").
    function automatic logic [6:0] tens_seg(input logic [6:0] tens);
        if ((BLANK_LZ != 0) && (tens == 7'h7E)) begin
            tens_seg = 7'h00;
        end else begin
            tens_seg = tens;
        end
    endfunction

    // Scan sequencing: next state, timer reload/decrement, frame boundary.
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r;
        boundary_s   = 1'b0;
        enter_dig0_s = 1'b0;
        if (!en) begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = ZERO_T;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s  = ST_DIG0;
                    timer_nxt_s  = ON_LOAD;
                    enter_dig0_s = 1'b1;
                end
                ST_DIG0: begin
                    if (timer_r != ZERO_T) begin
                        timer_nxt_s = timer_r - ONE_T;
                    end else if (GAP_CYCLES > 0) begin
                        state_nxt_s = ST_GAP0;
                        timer_nxt_s = GAP_LOAD;
                    end else begin
                        state_nxt_s = ST_DIG1;
                        timer_nxt_s = ON_LOAD;
                    end
                end
                ST_GAP0: begin
                    if (timer_r != ZERO_T) begin
                        timer_nxt_s = timer_r - ONE_T;
                    end else begin
                        state_nxt_s = ST_DIG1;
                        timer_nxt_s = ON_LOAD;
                    end
                end
                ST_DIG1: begin
                    if (timer_r != ZERO_T) begin
                        timer_nxt_s = timer_r - ONE_T;
                    end else if (GAP_CYCLES > 0) begin
                        state_nxt_s = ST_GAP1;
                        timer_nxt_s = GAP_LOAD;
                    end else begin
                        state_nxt_s  = ST_DIG0;
                        timer_nxt_s  = ON_LOAD;
                        boundary_s   = 1'b1;
                        enter_dig0_s = 1'b1;
                    end
                end
                ST_GAP1: begin
                    if (timer_r != ZERO_T) begin
                        timer_nxt_s = timer_r - ONE_T;
                    end else begin
                        state_nxt_s  = ST_DIG0;
                        timer_nxt_s  = ON_LOAD;
                        boundary_s   = 1'b1;
                        enter_dig0_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = ZERO_T;
                end
            endcase
        end
    end

    // Pending slot and shadow: accept when empty, commit on every DIG0 entry.
    // A transfer needs an empty slot and a commit needs a full one, so the two
    // can never collide.
    always_comb begin
        xfer_s          = s_valid && s_ready_r;
        commit_s        = enter_dig0_s && pend_full_r;
        shadow_nxt_s    = shadow_r;
        pend_full_nxt_s = pend_full_r;
        pend_nxt_s      = pend_r;
        if (commit_s) begin
            shadow_nxt_s    = pend_r;
            pend_full_nxt_s = 1'b0;
        end else if (xfer_s) begin
            pend_nxt_s      = s_data;
            pend_full_nxt_s = 1'b1;
        end else begin
            pend_full_nxt_s = pend_full_r;
        end
    end

    // Output decode from the next state and next shadow so the registered
    // outputs change on the same edge as the state.
    always_comb begin
        seg_nxt_s = 7'h00;
        dig_nxt_s = 2'b11;
        case (state_nxt_s)
            ST_DIG0: begin
                seg_nxt_s = shadow_nxt_s[6:0];
                dig_nxt_s = 2'b10;
            end
            ST_DIG1: begin
                seg_nxt_s = tens_seg(shadow_nxt_s[13:7]);
                dig_nxt_s = 2'b01;
            end
            default: begin
                seg_nxt_s = 7'h00;
                dig_nxt_s = 2'b11;
            end
        endcase
    end

    // State, data and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            timer_r      <= ZERO_T;
            pend_full_r  <= 1'b0;
            pend_r       <= 14'h0000;
            shadow_r     <= 14'h0000;
            s_ready_r    <= 1'b1;
            seg_out_r    <= 7'h00;
            dig_en_n_r   <= 2'b11;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            timer_r      <= timer_nxt_s;
            pend_full_r  <= pend_full_nxt_s;
            pend_r       <= pend_nxt_s;
            shadow_r     <= shadow_nxt_s;
            s_ready_r    <= !pend_full_nxt_s;
            seg_out_r    <= seg_nxt_s;
            dig_en_n_r   <= dig_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

endmodule
